seg7_scan_reader: RTL and testbench
===================================

SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 Parameter STABLE_CYC, default 4, number of consecutive identical synchronized samples that constitute one capture (legal range 2..255).
REQ-002 CLOCK_50  input  1  sole clock, all logic on rising edge.
REQ-003 RESET  input  1  reset, synchronous, active-high.
REQ-004 SEG  input  7  active-low segment pattern of the currently driven digit, bit0=a ... bit6=g.
REQ-005 DIG_N  input  4  active-low digit enables of a time-multiplexed 4-digit display; bit k low selects digit k.
REQ-006 VALUE  output  16  last completed word, digit k in bits 4k+3:4k.
REQ-007 VALID  output  1  one-cycle pulse when VALUE/DIGIT_ERR/ERR are updated.
REQ-008 DIGIT_ERR  output  4  bit k set if digit k of the last word carried an undecodable pattern.
REQ-009 ERR  output  1  OR of DIGIT_ERR.

Function
REQ-010 SEG and DIG_N shall pass through a two-flop synchronizer before any use.
REQ-011 The block shall hold a stability counter that resets to 0 whenever the synchronized {DIG_N,SEG} pair differs from the previous cycle and otherwise increments, saturating at STABLE_CYC.
REQ-012 A capture shall occur exactly in the cycle the counter reaches STABLE_CYC-1 (i.e. the STABLE_CYC-th identical sample); at most one capture per unchanged pair.
REQ-013 A capture shall be discarded unless exactly one DIG_N bit is low (all-high blanking and multi-digit overlap are ignored).
REQ-014 Inverse decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110 (SEG bit6..bit0).
REQ-015 Any other pattern shall store nibble 0 and set the digit's bad flag.
REQ-016 FSM states: IDLE, COLLECT, DONE.
REQ-017 IDLE: capture of digit 0 stores slot 0, sets seen=0001, bad per REQ-015, goes to COLLECT; captures of digits 1..3 ignored.
REQ-018 COLLECT: capture of digit k (k=1..3) overwrites slot k, sets seen[k], updates bad[k]; repeated capture of same digit overwrites.
REQ-019 COLLECT: capture of digit 0 restarts the sweep (shadow slot 0 rewritten, seen=0001, bad reset to new digit-0 flag only).
REQ-020 COLLECT: when seen becomes 1111 the next state shall be DONE.
REQ-021 DONE (one cycle): VALUE<=shadow, DIGIT_ERR<=bad, ERR<=|bad, VALID=1, seen cleared, next state IDLE; capture arriving in this cycle is ignored.
REQ-022 VALID shall be 1 only in DONE; VALUE/DIGIT_ERR/ERR shall hold between pulses.
REQ-023 Latency: pin change to capture = 2 + STABLE_CYC cycles; last capture to VALID = 1 cycle.
REQ-024 Counter and slot indices shall not wrap; no arithmetic overflow beyond saturation in REQ-011.

Reset
REQ-025 RESET shall force VALUE=0, VALID=0, DIGIT_ERR=0, ERR=0, state IDLE, seen=0, bad=0, counter=0.
REQ-026 RESET shall load synchronizer flops with SEG=7'h7F, DIG_N=4'hF so no capture occurs in the first STABLE_CYC cycles after release.
REQ-027 RESET mid-sweep shall discard all partial slots; no VALID until a fresh sweep from digit 0 completes.

Verification
REQ-028 STABLE_CYC=4; digits 0..3 each held 8 cycles showing patterns for 1,2,3,4 -> single VALID, VALUE=16'h4321, DIGIT_ERR=0, ERR=0.
REQ-029 Same sweep, digit 2 shows 7'b1111111 -> VALUE=16'h4021, DIGIT_ERR=4'b0100, ERR=1.
REQ-030 Each digit held only 3 cycles -> no capture, VALID never asserts, outputs keep prior values.
REQ-031 DIG_N=4'b0011 held 10 cycles mid-sweep -> ignored; sweep completes normally on later legal digits.
REQ-032 Digits 0(5),1(6),0(A),1(B),2(C),3(D) -> one VALID, VALUE=16'hDCBA.
REQ-033 RESET pulse after digit 1 captured -> all outputs 0; digits 2,3 then shown give no VALID.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers the 16-bit word shown on a multiplexed 4-digit 7-segment display
module seg7_scan_reader #(
  parameter int STABLE_CYC = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG_N,
  output logic [15:0] VALUE,
  output logic        VALID,
  output logic [3:0]  DIGIT_ERR,
  output logic        ERR
);

  localparam logic [7:0]  CNT_MAX   = 8'(STABLE_CYC);
  localparam logic [7:0]  CNT_CAP   = 8'(STABLE_CYC - 1);
  localparam logic [10:0] PINS_IDLE = 11'h7FF;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  logic [10:0] sync1;
  logic [10:0] sync2;
  logic [7:0]  stable_cnt;
  logic        one_digit;
  logic [1:0]  cap_idx;
  logic [3:0]  cap_nib;
  logic        cap_bad;
  logic        capture;
  state_t      state;
  state_t      state_d;
  logic [15:0] shadow;
  logic [15:0] shadow_d;
  logic [3:0]  seen;
  logic [3:0]  seen_d;
  logic [3:0]  bad;
  logic [3:0]  bad_d;

  // Two-flop synchronizer; reset preloads a blank display so nothing is captured right after release.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1 <= PINS_IDLE;
      sync2 <= PINS_IDLE;
    end else begin
      sync1 <= {DIG_N, SEG};
      sync2 <= sync1;
    end
  end

  // Counts how many consecutive cycles sync2 has held its value (0 = first sample), saturating.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      stable_cnt <= 8'd0;
    end else if (sync1 != sync2) begin
      stable_cnt <= 8'd0;
    end else if (stable_cnt != CNT_MAX) begin
      stable_cnt <= stable_cnt + 8'd1;
    end
  end

  // Accept only a single active digit enable; blanking and overlap are not digits.
  always_comb begin
    one_digit = 1'b1;
    cap_idx   = 2'd0;
    case (sync2[10:7])
      4'b1110: cap_idx = 2'd0;
      4'b1101: cap_idx = 2'd1;
      4'b1011: cap_idx = 2'd2;
      4'b0111: cap_idx = 2'd3;
      default: one_digit = 1'b0;
    endcase
  end

  // Inverse 7-segment decode (active-low, g..a); unknown patterns read as 0 and flag bad.
  always_comb begin
    cap_nib = 4'h0;
    cap_bad = 1'b0;
    case (sync2[6:0])
      7'b1000000: cap_nib = 4'h0;
      7'b1111001: cap_nib = 4'h1;
      7'b0100100: cap_nib = 4'h2;
      7'b0110000: cap_nib = 4'h3;
      7'b0011001: cap_nib = 4'h4;
      7'b0010010: cap_nib = 4'h5;
      7'b0000010: cap_nib = 4'h6;
      7'b1011000: cap_nib = 4'h7;
      7'b0000000: cap_nib = 4'h8;
      7'b0010000: cap_nib = 4'h9;
      7'b0001000: cap_nib = 4'hA;
      7'b0000011: cap_nib = 4'hB;
      7'b1000110: cap_nib = 4'hC;
      7'b0100001: cap_nib = 4'hD;
      7'b0000110: cap_nib = 4'hE;
      7'b0001110: cap_nib = 4'hF;
      default:    cap_bad = 1'b1;
    endcase
  end

  // The counter passes CNT_CAP exactly once per unchanged pair, giving a single capture.
  assign capture = (stable_cnt == CNT_CAP) && one_digit;

  // Sweep assembly: digit 0 opens (or restarts) a word, digits 1..3 fill it in.
  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    seen_d   = seen;
    bad_d    = bad;
    case (state)
      IDLE: begin
        if (capture && (cap_idx == 2'd0)) begin
          shadow_d[3:0] = cap_nib;
          seen_d        = 4'b0001;
          bad_d         = {3'b000, cap_bad};
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (capture) begin
          if (cap_idx == 2'd0) begin
            shadow_d[3:0] = cap_nib;
            seen_d        = 4'b0001;
            bad_d         = {3'b000, cap_bad};
          end else begin
            shadow_d[{cap_idx, 2'b00} +: 4] = cap_nib;
            seen_d[cap_idx]                 = 1'b1;
            bad_d[cap_idx]                  = cap_bad;
          end
        end
        if (seen_d == 4'hF) begin
          state_d = DONE;
        end
      end
      DONE: begin
        seen_d  = 4'b0000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and shadow registers; results publish on entry to DONE so they are valid alongside VALID.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state     <= IDLE;
      shadow    <= 16'h0000;
      seen      <= 4'b0000;
      bad       <= 4'b0000;
      VALUE     <= 16'h0000;
      DIGIT_ERR <= 4'b0000;
      ERR       <= 1'b0;
    end else begin
      state  <= state_d;
      shadow <= shadow_d;
      seen   <= seen_d;
      bad    <= bad_d;
      if ((state == COLLECT) && (state_d == DONE)) begin
        VALUE     <= shadow_d;
        DIGIT_ERR <= bad_d;
        ERR       <= |bad_d;
      end
    end
  end

  assign VALID = (state == DONE);

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - directed bench with a sweep-level reference model for seg7_scan_reader
module tb_seg7_scan_reader;

  localparam int S = 4;
  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] DX = 4'b1111;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig_n = 4'hF;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_err;
  logic        err;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int vcount = 0;
  int vcyc = 0;
  bit started = 1'b0;

  logic [15:0] exp_value = 16'h0;
  logic [3:0]  exp_derr = 4'h0;
  logic        exp_valid = 1'b0;

  seg7_scan_reader #(.STABLE_CYC(S)) dut (
    .CLOCK_50 (clk),
    .RESET    (reset),
    .SEG      (seg),
    .DIG_N    (dig_n),
    .VALUE    (value),
    .VALID    (valid),
    .DIGIT_ERR(digit_err),
    .ERR      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a capture is a run of S identical raw pin samples with one digit enabled,
  // acted on two cycles later (synchronizer); a word completes once digits 0..3 are seen after a digit 0.
  initial begin
    logic [10:0] last_in;
    logic [11:0] pipe0;
    logic [11:0] pipe1;
    logic [11:0] act;
    logic [10:0] cur;
    logic [15:0] m_word;
    logic [3:0]  m_seen;
    logic [3:0]  m_bad;
    bit          m_active;
    bit          m_done;
    int          run;
    int          k;
    int          nib;
    last_in = 11'h7FF; pipe0 = '0; pipe1 = '0; run = 1;
    m_word = '0; m_seen = '0; m_bad = '0; m_active = 0; m_done = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      cur = {dig_n, seg};
      if (reset) begin
        last_in = 11'h7FF; run = 1; pipe0 = '0; pipe1 = '0;
        m_word = '0; m_seen = '0; m_bad = '0; m_active = 0; m_done = 0;
        exp_value = '0; exp_derr = '0; exp_valid = 1'b0;
      end else begin
        act = pipe1;
        pipe1 = pipe0;
        if (cur == last_in) begin
          if (run <= S) run = run + 1;
        end else begin
          run = 1;
        end
        last_in = cur;
        pipe0 = (run == S && $countones(~cur[10:7]) == 1) ? {1'b1, cur} : 12'h0;
        exp_valid = 1'b0;
        if (m_done) begin
          m_done = 0;
        end else if (act[11]) begin
          k = 0;
          for (int i = 0; i < 4; i++) if (!act[7 + i]) k = i;
          nib = -1;
          for (int i = 0; i < 16; i++) if (PAT[i] == act[6:0]) nib = i;
          if (k == 0) begin
            m_active = 1;
            m_seen = 4'b0001;
            m_bad = 4'b0000;
          end
          if (m_active) begin
            m_word[4*k +: 4] = (nib < 0) ? 4'h0 : 4'(nib);
            m_seen[k] = 1'b1;
            m_bad[k] = (nib < 0);
            if (m_seen == 4'hF) begin
              exp_value = m_word;
              exp_derr = m_bad;
              exp_valid = 1'b1;
              m_done = 1;
              m_active = 0;
              m_seen = '0;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("valid", {31'b0, valid}, {31'b0, exp_valid});
        chk("value", {16'b0, value}, {16'b0, exp_value});
        chk("digit_err", {28'b0, digit_err}, {28'b0, exp_derr});
        chk("err", {31'b0, err}, {31'b0, |exp_derr});
        if (valid === 1'b1) begin
          vcount = vcount + 1;
          vcyc = cyc;
        end
      end
    end
  end

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_n = d;
    seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] e, input int n);
    hold(D0, PAT[a], n);
    hold(D1, PAT[b], n);
    hold(D2, PAT[c], n);
    hold(D3, PAT[e], n);
    hold(DX, 7'h7F, 4);
  endtask

  initial begin
    int v0;
    int t3;
    @(posedge clk);
    #1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_value", {16'b0, value}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_derr", {28'b0, digit_err}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    reset = 1'b0;

    // Clean sweep 1,2,3,4 with latency measurement on the last digit.
    v0 = vcount;
    hold(D0, PAT[1], 8);
    hold(D1, PAT[2], 8);
    hold(D2, PAT[3], 8);
    t3 = cyc;
    hold(D3, PAT[4], 8);
    hold(DX, 7'h7F, 4);
    chk("s1_pulses", vcount - v0, 1);
    chk("s1_value", {16'b0, value}, 32'h4321);
    chk("s1_model", {16'b0, exp_value}, 32'h4321);
    chk("s1_derr", {28'b0, digit_err}, 32'h0);
    chk("s1_latency", vcyc - t3, 2 + S);

    // Digit 2 blank -> bad digit.
    v0 = vcount;
    dig_n = D0; seg = PAT[1]; repeat (8) @(posedge clk); #1;
    hold(D1, PAT[2], 8);
    hold(D2, 7'h7F, 8);
    hold(D3, PAT[4], 8);
    hold(DX, 7'h7F, 4);
    chk("s2_pulses", vcount - v0, 1);
    chk("s2_value", {16'b0, value}, 32'h4021);
    chk("s2_derr", {28'b0, digit_err}, 32'h4);
    chk("s2_err", {31'b0, err}, 32'h1);

    // Digits held too briefly -> nothing captured, outputs hold.
    v0 = vcount;
    sweep(4'h5, 4'h6, 4'h7, 4'h8, 3);
    chk("s3_pulses", vcount - v0, 0);
    chk("s3_value", {16'b0, value}, 32'h4021);
    chk("s3_err", {31'b0, err}, 32'h1);

    // Two-digit overlap mid-sweep is ignored.
    v0 = vcount;
    hold(D0, PAT[9], 8);
    hold(4'b0011, PAT[2], 10);
    hold(D1, PAT[8], 8);
    hold(D2, PAT[7], 8);
    hold(D3, PAT[6], 8);
    hold(DX, 7'h7F, 4);
    chk("s4_pulses", vcount - v0, 1);
    chk("s4_value", {16'b0, value}, 32'h6789);
    chk("s4_err", {31'b0, err}, 32'h0);

    // Digit 0 restarts the sweep.
    v0 = vcount;
    hold(D0, PAT[5], 8);
    hold(D1, PAT[6], 8);
    sweep(4'hA, 4'hB, 4'hC, 4'hD, 8);
    chk("s5_pulses", vcount - v0, 1);
    chk("s5_value", {16'b0, value}, 32'hDCBA);
    chk("s5_model", {16'b0, exp_value}, 32'hDCBA);

    // Reset mid-sweep discards partial slots.
    v0 = vcount;
    hold(D0, PAT[1], 8);
    hold(D1, PAT[2], 8);
    hold(DX, 7'h7F, 2);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("s6_rst_value", {16'b0, value}, 32'h0);
    chk("s6_rst_err", {31'b0, err}, 32'h0);
    hold(D2, PAT[3], 8);
    hold(D3, PAT[4], 8);
    hold(DX, 7'h7F, 4);
    chk("s6_pulses", vcount - v0, 0);
    chk("s6_value", {16'b0, value}, 32'h0);
    chk("s6_derr", {28'b0, digit_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
